// File: rtl/plru_set_assoc.sv
// rtl/plru_set_assoc.sv - per-set tree pseudo-LRU replacement controller with valid tracking and way locking
// Victim lookup uses pre-edge state and is registered, so results arrive one cycle after the request.
module plru_set_assoc #(
  parameter int SETS = 16,
  parameter int WAYS = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 flush_i,
  input  logic                                 access_valid_i,
  input  logic [(SETS > 1 ? $clog2(SETS) : 1)-1:0] access_set_i,
  input  logic [$clog2(WAYS)-1:0]              access_way_i,
  input  logic                                 fill_valid_i,
  input  logic [(SETS > 1 ? $clog2(SETS) : 1)-1:0] fill_set_i,
  input  logic [$clog2(WAYS)-1:0]              fill_way_i,
  input  logic                                 inval_valid_i,
  input  logic [(SETS > 1 ? $clog2(SETS) : 1)-1:0] inval_set_i,
  input  logic [$clog2(WAYS)-1:0]              inval_way_i,
  input  logic [WAYS-1:0]                      lock_mask_i,
  input  logic                                 victim_req_i,
  input  logic [(SETS > 1 ? $clog2(SETS) : 1)-1:0] victim_set_i,
  output logic                                 victim_valid_o,
  output logic [$clog2(WAYS)-1:0]              victim_way_o,
  output logic                                 victim_is_invalid_o,
  output logic                                 victim_none_o
);

  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WW = $clog2(WAYS);

  logic [WAYS-2:0] tree_q  [SETS];
  logic [WAYS-2:0] tree_d  [SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];

  // Point every node on w's root-to-leaf path away from w.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t, input logic [WW-1:0] w);
    logic [WAYS-2:0] r;
    logic [WAYS-2:0] mask;
    logic [WW-1:0]   wsh;
    logic            b;
    int              idx;
    r   = t;
    idx = 0;
    for (int l = 0; l < WW; l++) begin
      wsh  = w >> (WW - 1 - l);
      b    = wsh[0];
      mask = {{(WAYS-2){1'b0}}, 1'b1} << idx;
      r    = b ? (r & ~mask) : (r | mask);
      idx  = 2 * idx + (b ? 2 : 1);
    end
    return r;
  endfunction

  // True when every way whose top lvl index bits equal pfx is locked.
  function automatic logic subtree_locked(input logic [WAYS-1:0] lk, input int pfx, input int lvl);
    logic r;
    r = 1'b1;
    for (int i = 0; i < WAYS; i++) begin
      if (((i >> (WW - lvl)) == pfx) && !lk[i]) r = 1'b0;
    end
    return r;
  endfunction

  // Next state per set: invalidate, then fill, then access, so access wins shared nodes.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      tree_d[s]  = tree_q[s];
      valid_d[s] = valid_q[s];
      if (inval_valid_i && inval_set_i == SW'(s)) begin
        valid_d[s][inval_way_i] = 1'b0;
      end
      if (fill_valid_i && fill_set_i == SW'(s)) begin
        valid_d[s][fill_way_i] = 1'b1;
        tree_d[s]              = touch(tree_d[s], fill_way_i);
      end
      if (access_valid_i && access_set_i == SW'(s)) begin
        tree_d[s] = touch(tree_d[s], access_way_i);
      end
    end
  end

  logic [WAYS-1:0] sel_valid;
  logic [WAYS-2:0] sel_tree;
  logic            found_inv;
  logic [WW-1:0]   inv_way;
  logic [WW-1:0]   tree_way;
  logic            all_locked;

  assign sel_valid  = valid_q[victim_set_i];
  assign sel_tree   = tree_q[victim_set_i];
  assign all_locked = &lock_mask_i;

  always_comb begin
    found_inv = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!sel_valid[i] && !lock_mask_i[i]) begin
        found_inv = 1'b1;
        inv_way   = WW'(i);
      end
    end
  end

  // Lock-aware walk: follow each node, but divert to the sibling when the chosen half is fully locked.
  always_comb begin
    logic [WAYS-2:0] tsh;
    logic            b;
    int              p;
    int              idx;
    p   = 0;
    idx = 0;
    for (int l = 0; l < WW; l++) begin
      tsh = sel_tree >> idx;
      b   = tsh[0];
      if (subtree_locked(lock_mask_i, 2 * p + (b ? 1 : 0), l + 1)) b = ~b;
      p   = 2 * p + (b ? 1 : 0);
      idx = 2 * idx + (b ? 2 : 1);
    end
    tree_way = WW'(p);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else if (flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= tree_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      victim_valid_o      <= 1'b0;
      victim_way_o        <= '0;
      victim_is_invalid_o <= 1'b0;
      victim_none_o       <= 1'b0;
    end else if (victim_req_i && !flush_i) begin
      victim_valid_o      <= 1'b1;
      victim_way_o        <= all_locked ? '0 : (found_inv ? inv_way : tree_way);
      victim_is_invalid_o <= !all_locked && found_inv;
      victim_none_o       <= all_locked;
    end else begin
      victim_valid_o      <= 1'b0;
      victim_way_o        <= '0;
      victim_is_invalid_o <= 1'b0;
      victim_none_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plru_set_assoc.sv
// tb/tb_plru_set_assoc.sv - directed self-checking bench for plru_set_assoc
// Result vector is {valid, way[2:0], is_invalid, none}.
module tb_plru_set_assoc;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       flush_i;
  logic       access_valid_i;
  logic [3:0] access_set_i;
  logic [2:0] access_way_i;
  logic       fill_valid_i;
  logic [3:0] fill_set_i;
  logic [2:0] fill_way_i;
  logic       inval_valid_i;
  logic [3:0] inval_set_i;
  logic [2:0] inval_way_i;
  logic [7:0] lock_mask_i;
  logic       victim_req_i;
  logic [3:0] victim_set_i;
  logic       victim_valid_o;
  logic [2:0] victim_way_o;
  logic       victim_is_invalid_o;
  logic       victim_none_o;

  int checks = 0;
  int errors = 0;
  logic [5:0] obs;
  logic [5:0] exp_v;

  plru_set_assoc #(.SETS(16), .WAYS(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .access_valid_i(access_valid_i), .access_set_i(access_set_i), .access_way_i(access_way_i),
    .fill_valid_i(fill_valid_i), .fill_set_i(fill_set_i), .fill_way_i(fill_way_i),
    .inval_valid_i(inval_valid_i), .inval_set_i(inval_set_i), .inval_way_i(inval_way_i),
    .lock_mask_i(lock_mask_i), .victim_req_i(victim_req_i), .victim_set_i(victim_set_i),
    .victim_valid_o(victim_valid_o), .victim_way_o(victim_way_o),
    .victim_is_invalid_o(victim_is_invalid_o), .victim_none_o(victim_none_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [5:0] result();
    return {victim_valid_o, victim_way_o, victim_is_invalid_o, victim_none_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; access_valid_i = 0; fill_valid_i = 0; inval_valid_i = 0; victim_req_i = 0;
    access_set_i = 0; access_way_i = 0; fill_set_i = 0; fill_way_i = 0;
    inval_set_i = 0; inval_way_i = 0; lock_mask_i = 0; victim_set_i = 0;
  endtask

  task automatic req(input logic [3:0] s, input logic [7:0] lk);
    victim_req_i = 1; victim_set_i = s; lock_mask_i = lk;
    step();
    victim_req_i = 0; lock_mask_i = 0;
  endtask

  task automatic fill(input logic [3:0] s, input logic [2:0] w);
    fill_valid_i = 1; fill_set_i = s; fill_way_i = w;
    step();
    fill_valid_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rstn_i = 0;
    step();
    obs = result(); checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 6'b0); end
    rstn_i = 1;
    step();
    req(4'd3, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b1, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_victim got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_fill_sequence();
    for (int w = 0; w < 8; w++) fill(4'd5, 3'(w));
    req(4'd5, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL full_set_victim got=%b exp=%b", obs, exp_v); end
    access_valid_i = 1; access_set_i = 5; access_way_i = 0;
    step();
    access_valid_i = 0;
    req(4'd5, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd4, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL after_access_victim got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_lock();
    req(4'd5, 8'h0F);
    obs = result(); exp_v = {1'b1, 3'd4, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lock_0f got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'hFF);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lock_all got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_invalidate();
    inval_valid_i = 1; inval_set_i = 5; inval_way_i = 6;
    step();
    inval_valid_i = 0;
    req(4'd5, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd6, 1'b1, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL inval_victim got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'h40);
    obs = result(); exp_v = {1'b1, 3'd4, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL inval_locked got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'hFF);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL inval_all_locked got=%b exp=%b", obs, exp_v); end
    fill(4'd5, 3'd6);
  endtask

  task automatic test_same_cycle();
    // Pre-update tree steers to way 2; after touching way 2 it steers to way 4.
    fill_valid_i = 1; fill_set_i = 5; fill_way_i = 2;
    victim_req_i = 1; victim_set_i = 5;
    step();
    fill_valid_i = 0; victim_req_i = 0;
    obs = result(); exp_v = {1'b1, 3'd2, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pre_update_victim got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd4, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_update_victim got=%b exp=%b", obs, exp_v); end
    fill_valid_i = 1; fill_set_i = 5; fill_way_i = 7;
    access_valid_i = 1; access_set_i = 5; access_way_i = 1;
    step();
    fill_valid_i = 0; access_valid_i = 0;
    req(4'd5, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd4, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL access_wins_root got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'h30);
    obs = result(); exp_v = {1'b1, 3'd6, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fill_path_node6 got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'hF0);
    obs = result(); exp_v = {1'b1, 3'd3, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL access_path_node1 got=%b exp=%b", obs, exp_v); end
    req(4'd5, 8'hFC);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL access_path_node3 got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_inval_fill_same_way();
    inval_valid_i = 1; inval_set_i = 2; inval_way_i = 3;
    fill_valid_i = 1; fill_set_i = 2; fill_way_i = 3;
    step();
    inval_valid_i = 0; fill_valid_i = 0;
    req(4'd2, 8'hF7);
    obs = result(); exp_v = {1'b1, 3'd3, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL inval_fill_ends_valid got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    victim_req_i = 1; victim_set_i = 5;
    step();
    obs = result(); exp_v = {1'b1, 3'd4, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_first got=%b exp=%b", obs, exp_v); end
    victim_set_i = 3;
    step();
    obs = result(); exp_v = {1'b1, 3'd0, 1'b1, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_second got=%b exp=%b", obs, exp_v); end
    victim_req_i = 0;
    step();
    obs = result(); checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL no_request_zero got=%b exp=%b", obs, 6'b0); end
  endtask

  task automatic test_flush();
    flush_i = 1;
    fill_valid_i = 1; fill_set_i = 5; fill_way_i = 0;
    victim_req_i = 1; victim_set_i = 5;
    step();
    flush_i = 0; fill_valid_i = 0; victim_req_i = 0;
    obs = result(); checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL flush_drops_req got=%b exp=%b", obs, 6'b0); end
    req(4'd5, 8'h00);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b1, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL after_flush_victim got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    req(4'd5, 8'hFF);
    obs = result(); exp_v = {1'b1, 3'd0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pre_async_reset got=%b exp=%b", obs, exp_v); end
    #2 rstn_i = 0;
    #1;
    obs = result(); checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL async_reset_outputs got=%b exp=%b", obs, 6'b0); end
    step();
    rstn_i = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_sequence();
    test_lock();
    test_invalidate();
    test_same_cycle();
    test_inval_fill_same_way();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
